// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: small input FIFO, runtime baud divisor,
// parity (none/even/odd), 1 or 2 stop bits, back-to-back frames with no idle gap.
module uart_tx_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [15:0]                   clk_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     DEF_DIV  = 16'(CLK_FREQ / BAUD_RATE);
    localparam logic [AW:0]     DEPTH_L  = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop, fifo_empty;
    logic [DATA_BITS-1:0] head;

    state_t               state, state_n;
    logic [15:0]          baud_cnt, baud_n;
    logic [3:0]           bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic [15:0]          div_lat, div_n, eff_div;
    logic                 par_en, par_en_n, par_bit, par_bit_n, stop2_lat, stop2_n;
    logic                 tx_n, busy_n, done_n, start_frame, wrap;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign s_ready    = (fifo_level < DEPTH_L);
    assign fifo_empty = (fifo_level == '0);
    assign push       = s_valid && s_ready;
    assign head       = mem[rd_ptr];

    assign eff_div = (clk_div == 16'd0) ? DEF_DIV :
                     (clk_div < 16'd3)  ? 16'd2   : clk_div;
    assign wrap    = (baud_cnt == div_lat - 16'd1);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Next-state logic; start_frame is shared by IDLE and the end of the last stop bit
    // so that queued words follow each other with zero idle cycles.
    always_comb begin
        state_n     = state;
        baud_n      = wrap ? 16'd0 : baud_cnt + 16'd1;
        bit_n       = bit_cnt;
        sh_n        = shreg;
        div_n       = div_lat;
        par_en_n    = par_en;
        par_bit_n   = par_bit;
        stop2_n     = stop2_lat;
        tx_n        = tx;
        busy_n      = tx_busy;
        done_n      = 1'b0;
        start_frame = 1'b0;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                baud_n = 16'd0;
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (!fifo_empty) start_frame = 1'b1;
            end
            START: begin
                if (wrap) begin
                    tx_n    = shreg[0];
                    sh_n    = shreg >> 1;
                    bit_n   = 4'd0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_n = 4'd0;
                        if (par_en) begin
                            tx_n    = par_bit;
                            state_n = PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = STOP;
                        end
                    end else begin
                        tx_n  = shreg[0];
                        sh_n  = shreg >> 1;
                        bit_n = bit_cnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (wrap) begin
                    tx_n    = 1'b1;
                    bit_n   = 4'd0;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (wrap) begin
                    if (stop2_lat && bit_cnt == 4'd0) begin
                        bit_n = 4'd1;
                    end else begin
                        done_n = 1'b1;
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            tx_n    = 1'b1;
                            busy_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Frame configuration is frozen here until the next pop.
        if (start_frame) begin
            pop       = 1'b1;
            sh_n      = head;
            div_n     = eff_div;
            par_en_n  = (parity_mode == 2'd1) || (parity_mode == 2'd2);
            par_bit_n = (^head) ^ (parity_mode == 2'd2);
            stop2_n   = stop2;
            tx_n      = 1'b0;
            busy_n    = 1'b1;
            bit_n     = 4'd0;
            baud_n    = 16'd0;
            state_n   = START;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 4'd0;
            shreg     <= '0;
            div_lat   <= 16'd2;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            stop2_lat <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            shreg     <= sh_n;
            div_lat   <= div_n;
            par_en    <= par_en_n;
            par_bit   <= par_bit_n;
            stop2_lat <= stop2_n;
            tx        <= tx_n;
            tx_busy   <= busy_n;
            tx_done   <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg: an 8-bit instance with runtime
// configuration and a 7-bit instance running at the default divisor.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid, s_ready;
    logic [15:0] clk_div;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        tx, tx_busy, tx_done;
    logic [2:0]  fifo_level;

    logic [6:0]  s_data7;
    logic        s_valid7, s_ready7, tx7, busy7, done7;
    logic [2:0]  level7;

    int vectors = 0;
    int errors  = 0;

    uart_tx_cfg #(.DATA_BITS(8), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .clk_div(clk_div), .parity_mode(parity_mode), .stop2(stop2),
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_level(fifo_level)
    );

    uart_tx_cfg #(.DATA_BITS(7)) u_dut7 (
        .clk(clk), .rst(rst), .s_data(s_data7), .s_valid(s_valid7), .s_ready(s_ready7),
        .clk_div(16'd0), .parity_mode(2'd0), .stop2(1'b0),
        .tx(tx7), .tx_busy(busy7), .tx_done(done7), .fifo_level(level7)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses s_valid for one edge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [7:0] d);
        s_data  = d;
        s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
    endtask

    // Called #1 after edge (S + offset), S being the edge that drove the start bit.
    // Checks tx at the first and last cycle of every bit, and busy/done along the way.
    task automatic checkFrame(input bit alt, input string name, input logic [8:0] data,
                              input int div, input int nbits, input bit par_en,
                              input bit par_val, input int nstop, input int offset);
        logic [15:0] exp_bits;
        int          total;
        int          bitn, pos;
        exp_bits    = '0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < nbits; i++) exp_bits[1+i] = data[i];
        total = 1 + nbits;
        if (par_en) begin
            exp_bits[total] = par_val;
            total++;
        end
        for (int s = 0; s < nstop; s++) begin
            exp_bits[total] = 1'b1;
            total++;
        end
        for (int c = offset; c < total * div; c++) begin
            bitn = c / div;
            pos  = c % div;
            if (pos == 0 || pos == div - 1) begin
                checkOutput({name, "_tx"}, 16'(alt ? tx7 : tx), 16'(exp_bits[bitn]));
                checkOutput({name, "_busy"}, 16'(alt ? busy7 : tx_busy), 16'd1);
            end
            if (pos == div - 1)
                checkOutput({name, "_done_early"}, 16'(alt ? done7 : tx_done), 16'd0);
            tick(1);
        end
    endtask

    logic [7:0] words [6];
    logic [2:0] exp_lev [6];
    logic       exp_rdy [6];

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; clk_div = 16'd4;
        parity_mode = 2'd0; stop2 = 1'b0; s_valid7 = 1'b0; s_data7 = '0;

        #2;
        checkOutput("rst_tx",      16'(tx),         16'd1);
        checkOutput("rst_busy",    16'(tx_busy),    16'd0);
        checkOutput("rst_done",    16'(tx_done),    16'd0);
        checkOutput("rst_level",   16'(fifo_level), 16'd0);
        checkOutput("rst_ready",   16'(s_ready),    16'd1);
        checkOutput("rst_tx7",     16'(tx7),        16'd1);
        tick(2);
        rst = 1'b0;
        tick(2);

        // 8N1 at divisor 4: 40-cycle frame, one cycle of start latency
        applyStimulus(8'h55);
        checkOutput("8n1_latency", 16'(tx),         16'd1);
        checkOutput("8n1_level",   16'(fifo_level), 16'd1);
        tick(1);
        checkFrame(0, "8n1", 9'h55, 4, 8, 0, 0, 1, 0);
        checkOutput("8n1_done",    16'(tx_done),    16'd1);
        checkOutput("8n1_busy_end",16'(tx_busy),    16'd0);
        checkOutput("8n1_tx_end",  16'(tx),         16'd1);
        tick(1);
        checkOutput("8n1_done_pulse", 16'(tx_done), 16'd0);
        tick(2);

        // Parity frames of 44 cycles: A5 even=0, A5 odd=1, 07 odd=0
        parity_mode = 2'd1;
        applyStimulus(8'hA5);
        tick(1);
        checkFrame(0, "even_a5", 9'hA5, 4, 8, 1, 0, 1, 0);
        checkOutput("even_done", 16'(tx_done), 16'd1);
        tick(2);
        parity_mode = 2'd2;
        applyStimulus(8'hA5);
        tick(1);
        checkFrame(0, "odd_a5", 9'hA5, 4, 8, 1, 1, 1, 0);
        checkOutput("odd_done", 16'(tx_done), 16'd1);
        tick(2);
        applyStimulus(8'h07);
        tick(1);
        parity_mode = 2'd0; stop2 = 1'b1; clk_div = 16'd8;
        checkFrame(0, "odd_07_frozen", 9'h07, 4, 8, 1, 0, 1, 0);
        checkOutput("odd07_done", 16'(tx_done), 16'd1);
        checkOutput("odd07_busy", 16'(tx_busy), 16'd0);
        tick(2);

        // Back-to-back 8N2 at divisor 2; second frame latches clk_div=1 (treated as 2)
        clk_div = 16'd2; parity_mode = 2'd0; stop2 = 1'b1;
        s_data = 8'hFF; s_valid = 1'b1;
        tick(2);
        s_valid = 1'b0;
        clk_div = 16'd1;
        checkOutput("b2b_level", 16'(fifo_level), 16'd1);
        checkFrame(0, "b2b1", 9'hFF, 2, 8, 0, 0, 2, 0);
        checkOutput("b2b1_done",  16'(tx_done),    16'd1);
        checkOutput("b2b1_start", 16'(tx),         16'd0);
        checkOutput("b2b1_busy",  16'(tx_busy),    16'd1);
        checkOutput("b2b1_level", 16'(fifo_level), 16'd0);
        checkFrame(0, "b2b2", 9'hFF, 2, 8, 0, 0, 2, 0);
        checkOutput("b2b2_done",  16'(tx_done),    16'd1);
        checkOutput("b2b2_busy",  16'(tx_busy),    16'd0);
        stop2 = 1'b0; clk_div = 16'd4;
        tick(2);

        // FIFO fill: six offered words, five accepted, sixth refused
        words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_lev = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        checkOutput("fill_ready0", 16'(s_ready), 16'd1);
        for (int k = 0; k < 6; k++) begin
            s_data  = words[k];
            s_valid = 1'b1;
            tick(1);
            checkOutput("fill_level", 16'(fifo_level), 16'(exp_lev[k]));
            checkOutput("fill_ready", 16'(s_ready),    16'(exp_rdy[k]));
        end
        s_valid = 1'b0;
        checkFrame(0, "fifo_w0", {1'b0, words[0]}, 4, 8, 0, 0, 1, 4);
        for (int k = 1; k < 5; k++) begin
            checkOutput("fifo_done",  16'(tx_done),    16'd1);
            checkOutput("fifo_start", 16'(tx),         16'd0);
            checkOutput("fifo_level", 16'(fifo_level), 16'(4 - k));
            checkFrame(0, "fifo_wn", {1'b0, words[k]}, 4, 8, 0, 0, 1, 0);
        end
        checkOutput("fifo_last_done", 16'(tx_done), 16'd1);
        checkOutput("fifo_last_busy", 16'(tx_busy), 16'd0);
        tick(8);
        checkOutput("fifo_no6_tx",   16'(tx),      16'd1);
        checkOutput("fifo_no6_busy", 16'(tx_busy), 16'd0);

        // Reset during data bit 3 of 0x00 with two words queued
        s_data = 8'h00; s_valid = 1'b1;
        tick(1);
        s_data = 8'hAA;
        tick(1);
        s_data = 8'hBB;
        tick(1);
        s_valid = 1'b0;
        checkOutput("rmf_level", 16'(fifo_level), 16'd2);
        tick(16);
        checkOutput("rmf_pre_tx", 16'(tx), 16'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rmf_tx",    16'(tx),         16'd1);
        checkOutput("rmf_level", 16'(fifo_level), 16'd0);
        checkOutput("rmf_busy",  16'(tx_busy),    16'd0);
        checkOutput("rmf_ready", 16'(s_ready),    16'd1);
        #2 rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            checkOutput("rmf_quiet_tx", 16'(tx), 16'd1);
        end
        checkOutput("rmf_quiet_busy", 16'(tx_busy), 16'd0);

        // 7-bit instance at the default divisor of 5208: 9-bit frame
        s_data7 = 7'h41; s_valid7 = 1'b1;
        tick(1);
        s_valid7 = 1'b0;
        checkOutput("d7_latency", 16'(tx7), 16'd1);
        tick(1);
        checkFrame(1, "d7", 9'h041, 5208, 7, 0, 0, 1, 0);
        checkOutput("d7_done", 16'(done7), 16'd1);
        checkOutput("d7_busy", 16'(busy7), 16'd0);
        checkOutput("d7_tx",   16'(tx7),   16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
